tap_window_reader: RTL and testbench
====================================

Name: tap_window_reader

Overview:
- Holds the N most recent input samples in a circular buffer and, after each accepted write, streams them out one per handshake: tap 0 is the newest sample x[n], and tap N-1 is the oldest sample x[n-N+1].
- Feeds the serial MAC / gradient datapath of the adaptive filter, so the filter needs no N-wide parallel tap bus.
- Acts as the read-out end of the sample delay line.

Parameters:
- BITSIZE, 8, sample width in bits.
- N, 16, window length (number of taps); legal range N >= 2.
- AW, $clog2(N), localparam, pointer/index width; not overridable.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  sample-write strobe; accepted only when in_ready=1.
- reg_in  input  BITSIZE  new sample x[n].
- in_ready  output  1  1 when a write can be accepted (FSM in IDLE).
- tap_out  output  BITSIZE  current tap sample.
- tap_idx  output  AW  index k of tap_out (0 = newest).
- tap_valid  output  1  tap_out/tap_idx are valid.
- tap_last  output  1  high with tap_valid when tap_idx = N-1.
- tap_ready  input  1  downstream accepts the current tap.
- overrun  output  1  sticky; set when enable=1 while in_ready=0.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset, sampled on the rising edge of clk.
- Reset:
  - All N buffer entries are cleared to 0, wr_ptr = 0 and FSM = IDLE.
  - Outputs after reset: tap_out = 0, tap_idx = 0, tap_valid = 0, tap_last = 0, overrun = 0, in_ready = 1.
  - Reset overrides everything, including mid-stream. An in-flight stream is abandoned with no tap_last.
- Storage:
  - Register array mem[0..N-1], not RAM, so that reset can clear every entry in one cycle.
- Write (IDLE, enable=1):
  - mem[wr_ptr] <= reg_in.
  - wr_ptr <= wr_ptr+1, wrapping from N-1 to 0 (explicit compare; N need not be a power of 2).
  - Latch newest = old wr_ptr, set k = 0 and go to STREAM.
- FSM states: IDLE and STREAM.
  - IDLE: in_ready = 1, tap_valid = 0. The transition to STREAM happens on an accepted write.
  - STREAM: in_ready = 0, tap_valid = 1.
  - Read address = newest - k mod N, computed with wrap-around (if newest < k, add N).
- Latency:
  - tap 0 is presented on the cycle after the write edge, with tap_valid=1 and tap_out equal to the just-written sample.
  - tap_out is registered.
- Handshake in STREAM:
  - A transfer occurs on a cycle where tap_valid && tap_ready.
  - On a transfer with k < N-1: k <= k+1, and tap_out/tap_idx update on the next edge.
  - On a transfer with k = N-1 (tap_last=1): return to IDLE and drop tap_valid the next cycle.
  - When tap_valid && !tap_ready: tap_out, tap_idx and tap_last hold stable (no change allowed).
  - Full throughput with tap_ready held at 1: N taps in N consecutive cycles, one write every N+1 cycles.
- Tap values:
  - tap k = x[n-k].
  - Entries never written since reset read 0, which matches a reset-cleared delay line.
- Overrun:
  - enable in STREAM is ignored: the buffer and pointer are not modified, and overrun <= 1.
  - overrun clears only on reset.
- Simultaneous events: the last-tap transfer plus enable on the same cycle. in_ready is 0 in that cycle, so the write is dropped and overrun is set. in_ready is a registered state decode with no combinational path from tap_ready.
- Width rules: no arithmetic on sample data. Pointer arithmetic is AW bits with wrap-around.

Decomposition:
- Shared package `saf_pkg`:
  - FSM state enum `tap_rd_state_t` (IDLE, STREAM).
  - Helper function `wrap_dec(ptr, k, N)` for modular pointer arithmetic.
- One natural sub-module, `circ_buf_regs`: the register array with write port, single combinational read port and synchronous clear.
- The FSM, counter and output registers stay in the top level.

Test Plan:
1. Reset, then one write of 0x05 with tap_ready=1:
   - Taps 0..15 are 0x05, 0, 0, ... 0, with tap_idx 0..15 and tap_last only at idx 15.
   - in_ready returns to 1 one cycle after tap_last.
2. Write 0x01..0x14 (20 samples, each after the previous stream completes). On the 20th stream:
   - Taps are 0x14, 0x13, ... 0x05.
   - This exercises wr_ptr wrap-around and the newest-k wrap.
3. Backpressure: during a stream, drop tap_ready at idx 3 for 4 cycles.
   - tap_out and tap_idx stay stable at 3.
   - The stream resumes at idx 4 with no tap lost or duplicated.
4. Overrun: pulse enable=1 with 0xAA at idx 7 of a stream.
   - The stream continues with the original values.
   - overrun=1 from the next cycle and stays set until reset.
   - A subsequent stream does not contain 0xAA.
5. Reset asserted at idx 9:
   - Next cycle tap_valid=0, in_ready=1, overrun=0.
   - A subsequent write of 0x33 streams 0x33 followed by 15 zeros.
6. Parameter sweep at N=5, BITSIZE=12 (non-power-of-2): write 0xABC, 0x123, 0x456.
   - Taps are 0x456, 0x123, 0xABC, 0, 0, with tap_last at idx 4.

Source files
------------

// File: rtl/saf_pkg.sv
// Shared types and pointer helpers for the adaptive-filter sample path.
package saf_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } tap_rd_state_t;

  // (ptr - k) mod n, valid for ptr < n and k <= n; n need not be a power of 2.
  function automatic int wrap_dec(input int ptr, input int k, input int n);
    return (ptr >= k) ? (ptr - k) : (ptr + n - k);
  endfunction

endpackage

// File: rtl/circ_buf_regs.sv
// Register-array circular buffer: one write port, one combinational read port,
// whole-array synchronous clear.
module circ_buf_regs #(
  parameter int BITSIZE = 8,
  parameter int N       = 16,
  parameter int AW      = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [AW-1:0]      wr_addr,
  input  logic [BITSIZE-1:0] wr_data,
  input  logic [AW-1:0]      rd_addr,
  output logic [BITSIZE-1:0] rd_data
);

  logic [BITSIZE-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/tap_window_reader.sv
// Streams the N most recent samples, newest first, one per handshake after
// every accepted write.
module tap_window_reader
  import saf_pkg::*;
#(
  parameter int BITSIZE = 8,
  parameter int N       = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [BITSIZE-1:0]       reg_in,
  output logic                     in_ready,
  output logic [BITSIZE-1:0]       tap_out,
  output logic [$clog2(N)-1:0]     tap_idx,
  output logic                     tap_valid,
  output logic                     tap_last,
  input  logic                     tap_ready,
  output logic                     overrun
);

  localparam int AW = $clog2(N);

  tap_rd_state_t      state, state_n;
  logic [AW-1:0]      wr_ptr, newest, rd_addr;
  logic [BITSIZE-1:0] rd_data;
  logic               wr_acc, xfer;

  // Handshake flags are pure decodes of the state register.
  assign in_ready  = (state == IDLE);
  assign tap_valid = (state == STREAM);
  assign wr_acc    = in_ready && enable;
  assign xfer      = tap_valid && tap_ready;

  // Address of the tap that follows the one currently on tap_out.
  assign rd_addr = AW'(wrap_dec(int'(newest), int'(tap_idx) + 1, N));

  circ_buf_regs #(
    .BITSIZE(BITSIZE),
    .N      (N),
    .AW     (AW)
  ) u_buf (
    .clk    (clk),
    .reset  (reset),
    .we     (wr_acc),
    .wr_addr(wr_ptr),
    .wr_data(reg_in),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (enable) state_n = STREAM;
      STREAM:  if (tap_ready && tap_last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      newest   <= '0;
      tap_out  <= '0;
      tap_idx  <= '0;
      tap_last <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state <= state_n;
      if (enable && !in_ready) overrun <= 1'b1;
      if (wr_acc) begin
        wr_ptr   <= (wr_ptr == AW'(N - 1)) ? '0 : wr_ptr + AW'(1);
        newest   <= wr_ptr;
        // Tap 0 is the sample being written, so bypass the array.
        tap_out  <= reg_in;
        tap_idx  <= '0;
        tap_last <= 1'b0;
      end else if (xfer && !tap_last) begin
        tap_out  <= rd_data;
        tap_idx  <= tap_idx + AW'(1);
        tap_last <= (tap_idx == AW'(N - 2));
      end
    end
  end

endmodule

// File: tb/tb_tap_window_reader.sv
// Scoreboard bench: N=16/8-bit instance for the main plan, N=5/12-bit for the sweep.
module tb_tap_window_reader;

  localparam int NA = 16, BA = 8, AA = 4;
  localparam int NB = 5,  BB = 12, AB = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, enable, tap_ready;
  logic [BA-1:0] reg_in, tap_out;
  logic [AA-1:0] tap_idx;
  logic          in_ready, tap_valid, tap_last, overrun;

  logic          reset_b, enable_b, tap_ready_b;
  logic [BB-1:0] reg_in_b, tap_out_b;
  logic [AB-1:0] tap_idx_b;
  logic          in_ready_b, tap_valid_b, tap_last_b, overrun_b;

  tap_window_reader #(.BITSIZE(BA), .N(NA)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .reg_in(reg_in), .in_ready(in_ready),
    .tap_out(tap_out), .tap_idx(tap_idx), .tap_valid(tap_valid), .tap_last(tap_last),
    .tap_ready(tap_ready), .overrun(overrun));

  tap_window_reader #(.BITSIZE(BB), .N(NB)) dut_b (
    .clk(clk), .reset(reset_b), .enable(enable_b), .reg_in(reg_in_b), .in_ready(in_ready_b),
    .tap_out(tap_out_b), .tap_idx(tap_idx_b), .tap_valid(tap_valid_b), .tap_last(tap_last_b),
    .tap_ready(tap_ready_b), .overrun(overrun_b));

  typedef struct {
    int idx;
    int data;
    bit last;
  } tap_exp_t;

  tap_exp_t qa[$], qb[$];
  int       hista[$], histb[$];
  int       checks = 0, failures = 0;
  bit       last_a = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected stream for the current history: tap k = x[n-k], zero beyond history.
  function automatic void push_a();
    for (int k = 0; k < NA; k++)
      qa.push_back('{idx: k, data: (k < hista.size()) ? hista[k] : 0, last: (k == NA - 1)});
  endfunction

  function automatic void push_b();
    for (int k = 0; k < NB; k++)
      qb.push_back('{idx: k, data: (k < histb.size()) ? histb[k] : 0, last: (k == NB - 1)});
  endfunction

  always @(negedge clk) begin
    tap_exp_t e;
    if (last_a) begin
      chk("a_ready_after_last", in_ready, 1);
      chk("a_valid_after_last", tap_valid, 0);
    end
    last_a = 1'b0;
    if (!reset && tap_valid && tap_ready) begin
      if (qa.size() == 0) chk("a_tap_unexpected", 1, 0);
      else begin
        e = qa.pop_front();
        chk("a_tap_idx", tap_idx, e.idx);
        chk("a_tap_out", tap_out, e.data);
        chk("a_tap_last", tap_last, e.last);
        last_a = tap_last;
      end
    end
  end

  always @(negedge clk) begin
    tap_exp_t e;
    if (!reset_b && tap_valid_b && tap_ready_b) begin
      if (qb.size() == 0) chk("b_tap_unexpected", 1, 0);
      else begin
        e = qb.pop_front();
        chk("b_tap_idx", tap_idx_b, e.idx);
        chk("b_tap_out", tap_out_b, e.data);
        chk("b_tap_last", tap_last_b, e.last);
      end
    end
  end

  task automatic wait_done_a();
    int n = 0;
    while (qa.size() != 0 || !in_ready) begin
      @(posedge clk); #1;
      n++;
      if (n > 200) begin chk("a_stream_timeout", 0, 1); return; end
    end
  endtask

  task automatic write_a(input logic [BA-1:0] v);
    wait_done_a();
    enable = 1'b1; reg_in = v;
    hista.push_front(int'(v));
    push_a();
    @(posedge clk); #1;
    enable = 1'b0;
  endtask

  task automatic wait_idx_a(input int target);
    int n = 0;
    while (!(tap_valid && int'(tap_idx) == target)) begin
      @(posedge clk); #1;
      n++;
      if (n > 200) begin chk("a_idx_timeout", 0, 1); return; end
    end
  endtask

  task automatic write_b(input logic [BB-1:0] v);
    int n = 0;
    while (qb.size() != 0 || !in_ready_b) begin
      @(posedge clk); #1;
      n++;
      if (n > 200) begin chk("b_stream_timeout", 0, 1); return; end
    end
    enable_b = 1'b1; reg_in_b = v;
    histb.push_front(int'(v));
    push_b();
    @(posedge clk); #1;
    enable_b = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; reg_in = '0; tap_ready = 1'b1;
    reset_b = 1'b1; enable_b = 1'b0; reg_in_b = '0; tap_ready_b = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tap_valid", tap_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_tap_out", tap_out, 0);
    chk("rst_tap_idx", tap_idx, 0);
    chk("rst_tap_last", tap_last, 0);
    chk("rst_overrun", overrun, 0);
    @(posedge clk); #1;
    reset = 1'b0; reset_b = 1'b0;

    // Single sample into a cleared window, then a full 20-sample sequence.
    write_a(8'h05);
    wait_done_a();
    for (int i = 1; i <= 20; i++) write_a(BA'(i));
    wait_done_a();

    // Backpressure on tap 3.
    write_a(8'h55);
    wait_idx_a(3);
    tap_ready = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("bp_valid", tap_valid, 1);
      chk("bp_idx", tap_idx, 3);
      chk("bp_out", tap_out, (qa.size() != 0) ? qa[0].data : -1);
      chk("bp_last", tap_last, 0);
    end
    @(posedge clk); #1;
    tap_ready = 1'b1;
    wait_done_a();

    // Overrun: write attempt mid-stream is dropped.
    chk("ovr_before", overrun, 0);
    write_a(8'h66);
    wait_idx_a(7);
    enable = 1'b1; reg_in = 8'hAA;
    @(posedge clk); #1;
    enable = 1'b0;
    @(negedge clk);
    chk("ovr_set", overrun, 1);
    wait_done_a();
    chk("ovr_sticky", overrun, 1);
    write_a(8'h77);
    wait_done_a();
    chk("ovr_sticky2", overrun, 1);

    // Reset mid-stream at tap 9.
    write_a(8'h88);
    wait_idx_a(9);
    reset = 1'b1; tap_ready = 1'b0;
    qa.delete(); hista.delete();
    @(posedge clk); #1;
    reset = 1'b0; tap_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", tap_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_overrun", overrun, 0);
    write_a(8'h33);
    wait_done_a();

    // Non-power-of-2 window.
    write_b(12'hABC);
    write_b(12'h123);
    write_b(12'h456);
    begin
      int n = 0;
      while (qb.size() != 0 || !in_ready_b) begin
        @(posedge clk); #1;
        n++;
        if (n > 200) begin chk("b_final_timeout", 0, 1); break; end
      end
    end
    chk("b_overrun", overrun_b, 0);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
